// File: rtl/clock_node_retune_sequencer.sv
// APB master that retunes one clock node: programs the override and setting
// registers, then polls the live frequency register until it matches or times out.
module clock_node_retune_sequencer #(
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
    parameter int unsigned POLL_LIMIT    = 256,
    parameter logic [31:0] SETTING_APPLY = 32'h0000_0001
) (
    input  logic        clock,
    input  logic        async_resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_frequency,
    input  logic [31:0] req_mindrift,
    input  logic [31:0] req_maxdrift,
    output logic        done_valid,
    output logic [1:0]  done_status,
    output logic [31:0] done_frequency,
    output logic        busy,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr
);
    localparam int CNT_W = $clog2(POLL_LIMIT + 1);
    localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_LIMIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;
    typedef enum logic [2:0] {W_FREQ, W_MIN, W_MAX, W_SET, POLL} step_t;

    state_t           state;
    state_t           state_nxt;
    step_t            step;
    logic [CNT_W-1:0] poll_cnt;
    logic [31:0]      freq_q;
    logic [31:0]      min_q;
    logic [31:0]      max_q;
    logic [31:0]      step_offset;
    logic [31:0]      step_wdata;
    logic             accept;
    logic             xfer_done;
    logic             poll_match;
    logic             poll_last;

    assign accept     = (state == S_IDLE) && req_valid;
    assign xfer_done  = (state == S_ACCESS) && pready;
    assign poll_match = (prdata == freq_q);
    assign poll_last  = (poll_cnt == POLL_LAST);

    always_ff @(posedge clock or negedge async_resetn) begin
        if (!async_resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (req_valid) state_nxt = S_SETUP;
            S_SETUP:  state_nxt = S_ACCESS;
            S_ACCESS: begin
                if (pready) begin
                    if (pslverr) begin
                        state_nxt = S_DONE;
                    end else if (step != POLL) begin
                        state_nxt = S_SETUP;
                    end else if (poll_match || poll_last) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_SETUP;
                    end
                end
            end
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Request words are only sampled at acceptance, so they need no reset.
    always_ff @(posedge clock) begin
        if (accept) begin
            freq_q <= req_frequency;
            min_q  <= req_mindrift;
            max_q  <= req_maxdrift;
        end
    end

    always_ff @(posedge clock or negedge async_resetn) begin
        if (!async_resetn) begin
            step           <= W_FREQ;
            poll_cnt       <= '0;
            done_status    <= 2'd0;
            done_frequency <= 32'd0;
        end else if (accept) begin
            step     <= W_FREQ;
            poll_cnt <= '0;
        end else if (xfer_done) begin
            if (pslverr) begin
                done_status <= 2'd1;
            end else if (step != POLL) begin
                step <= step_t'(step + 3'd1);
            end else if (poll_match) begin
                done_status    <= 2'd0;
                done_frequency <= prdata;
            end else if (poll_last) begin
                done_status    <= 2'd2;
                done_frequency <= prdata;
            end else begin
                poll_cnt <= poll_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        step_offset = 32'h08;
        step_wdata  = 32'd0;
        case (step)
            W_FREQ:  begin step_offset = 32'h34; step_wdata = freq_q;        end
            W_MIN:   begin step_offset = 32'h38; step_wdata = min_q;         end
            W_MAX:   begin step_offset = 32'h3C; step_wdata = max_q;         end
            W_SET:   begin step_offset = 32'h30; step_wdata = SETTING_APPLY; end
            default: begin step_offset = 32'h08; step_wdata = 32'd0;         end
        endcase
    end

    // Bus outputs decode straight from state so an async reset idles the bus at once.
    always_comb begin
        req_ready  = 1'b0;
        busy       = 1'b1;
        done_valid = 1'b0;
        psel       = 1'b0;
        penable    = 1'b0;
        pwrite     = 1'b0;
        paddr      = 32'd0;
        pwdata     = 32'd0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            S_SETUP, S_ACCESS: begin
                psel    = 1'b1;
                penable = (state == S_ACCESS);
                pwrite  = (step != POLL);
                paddr   = BASE_ADDR + step_offset;
                pwdata  = step_wdata;
            end
            S_DONE:  done_valid = 1'b1;
            default: busy = 1'b0;
        endcase
    end
endmodule
